// File: rtl/noc_vc_bridge_if.sv
// -----------------------------------------------------------------------------
// noc_vc_pkg / noc_vc_bridge_if
//
// Purpose:
//   Shared flit definitions and the router local-port bundle used by the
//   noc_vc_bridge network interface.
//
// Package contents:
//   FLIT_DATA_SIZE, DEST_ADDR_SIZE_X/Y, VC_NUM, VC_ID_W
//   flit_label_t  HEAD / BODY / TAIL / HEADTAIL
//   flit_t        {flit_label, vc_id, data}
//
// Interface signals (router local port):
//   router_data_in / router_valid_in            flit injected into the router
//   router_is_on_off_in / _is_allocatable_in    per-VC status towards the router
//   router_data_out / router_valid_out          flit ejected from the router
//   router_is_on_off_out                        downstream per-VC on/off
//
// Modports:
//   master  bridge side (drives injection and status)
//   slave   router side (drives ejection and on/off)
// -----------------------------------------------------------------------------
package noc_vc_pkg;
    localparam int FLIT_DATA_SIZE   = 32;
    localparam int DEST_ADDR_SIZE_X = 4;
    localparam int DEST_ADDR_SIZE_Y = 4;
    localparam int VC_NUM           = 2;
    localparam int VC_ID_W          = (VC_NUM > 1) ? $clog2(VC_NUM) : 1;

    typedef enum logic [1:0] {
        HEAD     = 2'd0,
        BODY     = 2'd1,
        TAIL     = 2'd2,
        HEADTAIL = 2'd3
    } flit_label_t;

    typedef struct packed {
        flit_label_t               flit_label;
        logic [VC_ID_W-1:0]        vc_id;
        logic [FLIT_DATA_SIZE-1:0] data;
    } flit_t;
endpackage

interface noc_vc_bridge_if #(
    parameter int NVC = noc_vc_pkg::VC_NUM
);
    noc_vc_pkg::flit_t router_data_in;
    logic              router_valid_in;
    logic [NVC-1:0]    router_is_on_off_in;
    logic [NVC-1:0]    router_is_allocatable_in;
    noc_vc_pkg::flit_t router_data_out;
    logic              router_valid_out;
    logic [NVC-1:0]    router_is_on_off_out;

    modport master (
        output router_data_in,
        output router_valid_in,
        output router_is_on_off_in,
        output router_is_allocatable_in,
        input  router_data_out,
        input  router_valid_out,
        input  router_is_on_off_out
    );

    modport slave (
        input  router_data_in,
        input  router_valid_in,
        input  router_is_on_off_in,
        input  router_is_allocatable_in,
        output router_data_out,
        output router_valid_out,
        output router_is_on_off_out
    );
endinterface

// File: rtl/noc_vc_bridge.sv
// -----------------------------------------------------------------------------
// noc_vc_bridge
//
// Purpose:
//   Network-interface bridge between one router local port and the local
//   TX/RX buffers. Header-prefixed words from the TX buffer are packetised
//   into HEAD/BODY/TAIL/HEADTAIL flits on a round-robin chosen VC under
//   per-VC on/off flow control. Ejected flits are written to the RX buffer,
//   single-flit packets produce a grant pulse, and per-VC packet framing is
//   checked into a sticky error flag.
//
// Ports:
//   clk_router, rst_router_n   clock, synchronous active-low reset
//   rtr (master modport)       router local port bundle
//   router_wrbuf_*             RX buffer (wafull in, wen/wdata out)
//   router_rdbuf_*             TX buffer (rempty/rdata in, ren out; data
//                              arrives the cycle after ren)
//   dla2noc_granted_*          grant fields and one-cycle strobe
//   err_seq                    sticky sequence-error flag
//   tx_pkt_cnt, rx_pkt_cnt     wrapping packet counters
// -----------------------------------------------------------------------------
module noc_vc_bridge
    import noc_vc_pkg::*;
#(
    parameter int NVC        = VC_NUM,
    parameter int LEN_W      = 8,
    parameter bit EJECT_HEAD = 1'b0,
    parameter int CNT_W      = 16
) (
    input  logic                        clk_router,
    input  logic                        rst_router_n,
    noc_vc_bridge_if.master             rtr,
    input  logic                        router_wrbuf_wafull,
    output logic                        router_wrbuf_wen,
    output logic [FLIT_DATA_SIZE-1:0]   router_wrbuf_wdata,
    input  logic                        router_rdbuf_rempty,
    output logic                        router_rdbuf_ren,
    input  logic [FLIT_DATA_SIZE-1:0]   router_rdbuf_rdata,
    output logic [DEST_ADDR_SIZE_X-1:0] dla2noc_granted_x,
    output logic [DEST_ADDR_SIZE_Y-1:0] dla2noc_granted_y,
    output logic [1:0]                  dla2noc_granted_dla,
    output logic                        dla2noc_granted_vld,
    output logic                        err_seq,
    output logic [CNT_W-1:0]            tx_pkt_cnt,
    output logic [CNT_W-1:0]            rx_pkt_cnt
);

    localparam int FDS = FLIT_DATA_SIZE;
    // head_pl occupies everything below the length field
    localparam int HPW = FDS - 11 - LEN_W;
    localparam flit_t FLIT_RST = '{flit_label: HEADTAIL, vc_id: '0, data: '0};

    typedef enum logic [1:0] {ST_IDLE, ST_HDR, ST_BODY} state_t;

    state_t               state_q, state_d;
    logic [VC_ID_W-1:0]   ptr_q, ptr_d;
    logic [VC_ID_W-1:0]   cur_vc_q, cur_vc_d;
    logic [LEN_W-1:0]     len_q, len_d;
    logic [LEN_W-1:0]     rd_left_q, rd_left_d;
    logic [LEN_W-1:0]     sent_q, sent_d;
    logic                 rd_pend_q, rd_pend_d;
    flit_t                flit_q, flit_d;
    logic                 flit_vld_q, flit_vld_d;
    logic [CNT_W-1:0]     tx_cnt_q, tx_cnt_d;
    logic                 ren;
    logic                 vc_found;
    logic [VC_ID_W-1:0]   vc_pick;
    logic [LEN_W-1:0]     hdr_len;

    logic                 wen_q, wen_d;
    logic [FDS-1:0]       wdata_q, wdata_d;
    logic                 gvld_q, gvld_d;
    logic [DEST_ADDR_SIZE_X-1:0] gx_q, gx_d;
    logic [DEST_ADDR_SIZE_Y-1:0] gy_q, gy_d;
    logic [1:0]           gdla_q, gdla_d;
    logic                 err_q, err_d;
    logic [NVC-1:0]       inpkt_q, inpkt_d;
    logic [CNT_W-1:0]     rx_cnt_q, rx_cnt_d;
    logic [VC_ID_W-1:0]   ej_vc;
    logic [HPW-1:0]       ej_hpl;

    // Round-robin VC choice: first VC with on/off set, scanning upward from
    // the one after the last VC used and wrapping around.
    always_comb begin : pick_proc
        int cand;
        cand     = 0;
        vc_found = 1'b0;
        vc_pick  = ptr_q;
        for (int i = 1; i <= NVC; i++) begin
            cand = (int'(ptr_q) + i) % NVC;
            if (!vc_found && rtr.router_is_on_off_out[cand[VC_ID_W-1:0]]) begin
                vc_found = 1'b1;
                vc_pick  = cand[VC_ID_W-1:0];
            end
        end
    end

    // Injection FSM. A read issued in one cycle has its data on rdata in the
    // next, where it is turned into a flit register load; rd_pend_q remembers
    // that a BODY-state read is outstanding so it is emitted even if on/off
    // drops in the meantime.
    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        cur_vc_d   = cur_vc_q;
        len_d      = len_q;
        rd_left_d  = rd_left_q;
        sent_d     = sent_q;
        rd_pend_d  = 1'b0;
        flit_d     = flit_q;
        flit_vld_d = 1'b0;
        tx_cnt_d   = tx_cnt_q;
        ren        = 1'b0;
        hdr_len    = router_rdbuf_rdata[FDS-12 -: LEN_W];

        unique case (state_q)
            ST_IDLE: begin
                if (!router_rdbuf_rempty && vc_found) begin
                    ren      = 1'b1;
                    ptr_d    = vc_pick;
                    cur_vc_d = vc_pick;
                    state_d  = ST_HDR;
                end
            end
            ST_HDR: begin
                // The length field is dropped from the outgoing head flit
                flit_d.data       = {router_rdbuf_rdata[FDS-1:FDS-11], {LEN_W{1'b0}},
                                     router_rdbuf_rdata[HPW-1:0]};
                flit_d.vc_id      = cur_vc_q;
                flit_d.flit_label = (hdr_len == '0) ? HEADTAIL : HEAD;
                flit_vld_d        = 1'b1;
                tx_cnt_d          = tx_cnt_q + 1'b1;
                len_d             = hdr_len;
                rd_left_d         = hdr_len;
                sent_d            = '0;
                state_d           = (hdr_len == '0) ? ST_IDLE : ST_BODY;
            end
            ST_BODY: begin
                ren = !router_rdbuf_rempty && rtr.router_is_on_off_out[cur_vc_q]
                      && (rd_left_q != '0);
                rd_pend_d = ren;
                if (ren) begin
                    rd_left_d = rd_left_q - 1'b1;
                end
                if (rd_pend_q) begin
                    flit_d.data  = router_rdbuf_rdata;
                    flit_d.vc_id = cur_vc_q;
                    flit_vld_d   = 1'b1;
                    sent_d       = sent_q + 1'b1;
                    if (sent_q == len_q - 1'b1) begin
                        flit_d.flit_label = TAIL;
                        state_d           = ST_IDLE;
                    end else begin
                        flit_d.flit_label = BODY;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Injection state register; reset abandons any packet in flight.
    always_ff @(posedge clk_router) begin
        if (!rst_router_n) begin
            state_q    <= ST_IDLE;
            ptr_q      <= VC_ID_W'(NVC - 1);
            cur_vc_q   <= '0;
            len_q      <= '0;
            rd_left_q  <= '0;
            sent_q     <= '0;
            rd_pend_q  <= 1'b0;
            flit_q     <= FLIT_RST;
            flit_vld_q <= 1'b0;
            tx_cnt_q   <= '0;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            cur_vc_q   <= cur_vc_d;
            len_q      <= len_d;
            rd_left_q  <= rd_left_d;
            sent_q     <= sent_d;
            rd_pend_q  <= rd_pend_d;
            flit_q     <= flit_d;
            flit_vld_q <= flit_vld_d;
            tx_cnt_q   <= tx_cnt_d;
        end
    end

    // Ejection path: decode the flit label, track per-VC packet framing and
    // flag any flit that does not fit the current framing. Erroneous flits are
    // still written so the data stream is not lost.
    always_comb begin
        ej_vc    = rtr.router_data_out.vc_id;
        ej_hpl   = rtr.router_data_out.data[HPW-1:0];
        wen_d    = 1'b0;
        wdata_d  = wdata_q;
        gvld_d   = 1'b0;
        gx_d     = gx_q;
        gy_d     = gy_q;
        gdla_d   = gdla_q;
        err_d    = err_q;
        inpkt_d  = inpkt_q;
        rx_cnt_d = rx_cnt_q;

        if (rtr.router_valid_out) begin
            unique case (rtr.router_data_out.flit_label)
                HEADTAIL: begin
                    gvld_d   = 1'b1;
                    gdla_d   = ej_hpl[1:0];
                    gy_d     = ej_hpl[2 +: DEST_ADDR_SIZE_Y];
                    gx_d     = ej_hpl[2 + DEST_ADDR_SIZE_Y +: DEST_ADDR_SIZE_X];
                    rx_cnt_d = rx_cnt_q + 1'b1;
                    if (EJECT_HEAD) begin
                        wen_d   = 1'b1;
                        wdata_d = rtr.router_data_out.data;
                    end
                    if (inpkt_q[ej_vc]) begin
                        err_d = 1'b1;
                    end
                end
                HEAD: begin
                    inpkt_d[ej_vc] = 1'b1;
                    if (EJECT_HEAD) begin
                        wen_d   = 1'b1;
                        wdata_d = rtr.router_data_out.data;
                    end
                    if (inpkt_q[ej_vc]) begin
                        err_d = 1'b1;
                    end
                end
                BODY: begin
                    wen_d   = 1'b1;
                    wdata_d = rtr.router_data_out.data;
                    if (!inpkt_q[ej_vc]) begin
                        err_d = 1'b1;
                    end
                end
                TAIL: begin
                    wen_d          = 1'b1;
                    wdata_d        = rtr.router_data_out.data;
                    inpkt_d[ej_vc] = 1'b0;
                    rx_cnt_d       = rx_cnt_q + 1'b1;
                    if (!inpkt_q[ej_vc]) begin
                        err_d = 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    // Ejection registers; err_seq only clears on reset.
    always_ff @(posedge clk_router) begin
        if (!rst_router_n) begin
            wen_q    <= 1'b0;
            wdata_q  <= '0;
            gvld_q   <= 1'b0;
            gx_q     <= '0;
            gy_q     <= '0;
            gdla_q   <= '0;
            err_q    <= 1'b0;
            inpkt_q  <= '0;
            rx_cnt_q <= '0;
        end else begin
            wen_q    <= wen_d;
            wdata_q  <= wdata_d;
            gvld_q   <= gvld_d;
            gx_q     <= gx_d;
            gy_q     <= gy_d;
            gdla_q   <= gdla_d;
            err_q    <= err_d;
            inpkt_q  <= inpkt_d;
            rx_cnt_q <= rx_cnt_d;
        end
    end

    assign router_rdbuf_ren             = ren;
    assign rtr.router_data_in           = flit_q;
    assign rtr.router_valid_in          = flit_vld_q;
    assign rtr.router_is_on_off_in      = {NVC{!router_wrbuf_wafull}};
    assign rtr.router_is_allocatable_in = ~inpkt_q;
    assign router_wrbuf_wen             = wen_q;
    assign router_wrbuf_wdata           = wdata_q;
    assign dla2noc_granted_vld          = gvld_q;
    assign dla2noc_granted_x            = gx_q;
    assign dla2noc_granted_y            = gy_q;
    assign dla2noc_granted_dla          = gdla_q;
    assign err_seq                      = err_q;
    assign tx_pkt_cnt                   = tx_cnt_q;
    assign rx_pkt_cnt                   = rx_cnt_q;

endmodule

// File: tb/tb_noc_vc_bridge.sv
// -----------------------------------------------------------------------------
// tb_noc_vc_bridge
//
// Directed bench for noc_vc_bridge (NVC=2, LEN_W=8, EJECT_HEAD=0). Injection
// is driven cycle by cycle against per-cycle expected ren/flit schedules; the
// ejection path is driven from a table of {inputs, expected outputs} rows.
// -----------------------------------------------------------------------------
module tb_noc_vc_bridge;
    import noc_vc_pkg::*;

    logic        clk = 1'b0;
    logic        rstN;
    logic        wafull;
    logic        wen;
    logic [31:0] wdata;
    logic        rempty;
    logic        ren;
    logic [31:0] rdata;
    logic [3:0]  gX;
    logic [3:0]  gY;
    logic [1:0]  gDla;
    logic        gVld;
    logic        errSeq;
    logic [15:0] txCnt;
    logic [15:0] rxCnt;

    int nCompared = 0;
    int nMismatched = 0;

    logic [31:0] txQ [$];

    logic [1:0]  onOffSched [16];
    int          expLbl [16];
    logic        expVc [16];
    logic [31:0] expDat [16];
    logic [15:0] expRenMask;

    typedef struct packed {
        logic        vld;
        flit_label_t lbl;
        logic        vc;
        logic [31:0] data;
        logic        wafull;
        logic        eWen;
        logic [31:0] eWdata;
        logic        eVld;
        logic [3:0]  eX;
        logic [3:0]  eY;
        logic [1:0]  eDla;
        logic        eErr;
        logic [15:0] eRx;
        logic [1:0]  eAlloc;
        logic [1:0]  eOnOff;
    } ejVec_t;

    ejVec_t vecs [10];

    noc_vc_bridge_if #(.NVC(2)) rtr ();

    noc_vc_bridge #(
        .NVC(2),
        .LEN_W(8),
        .EJECT_HEAD(1'b0),
        .CNT_W(16)
    ) dut (
        .clk_router          (clk),
        .rst_router_n        (rstN),
        .rtr                 (rtr),
        .router_wrbuf_wafull (wafull),
        .router_wrbuf_wen    (wen),
        .router_wrbuf_wdata  (wdata),
        .router_rdbuf_rempty (rempty),
        .router_rdbuf_ren    (ren),
        .router_rdbuf_rdata  (rdata),
        .dla2noc_granted_x   (gX),
        .dla2noc_granted_y   (gY),
        .dla2noc_granted_dla (gDla),
        .dla2noc_granted_vld (gVld),
        .err_seq             (errSeq),
        .tx_pkt_cnt          (txCnt),
        .rx_pkt_cnt          (rxCnt)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    function automatic logic [31:0] mkHdr(input logic [3:0] x, input logic [3:0] y,
                                          input logic [2:0] l, input logic [7:0] len,
                                          input logic [12:0] pl);
        return {x, y, l, len, pl};
    endfunction

    function automatic logic [31:0] stripLen(input logic [31:0] h);
        return {h[31:21], 8'h00, h[12:0]};
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        nCompared++;
        if (act !== exp) begin
            nMismatched++;
            $display("[TB] FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endtask

    task automatic pushWord(input logic [31:0] w);
        txQ.push_back(w);
        rempty = 1'b0;
    endtask

    task automatic clearSched();
        for (int c = 0; c < 16; c++) begin
            onOffSched[c] = 2'b11;
            expLbl[c]     = -1;
            expVc[c]      = 1'b0;
            expDat[c]     = 32'h0;
        end
        expRenMask = 16'h0;
    endtask

    // Runs nCyc injection cycles starting just after a clock edge, checking
    // ren and the injected flit in each cycle and modelling the TX buffer.
    task automatic runInj(input int nCyc, input string tag);
        logic sRen;
        for (int c = 0; c < nCyc; c++) begin
            rtr.router_is_on_off_out = onOffSched[c];
            #2;
            sRen = ren;
            checkOutput($sformatf("%s ren c%0d", tag, c), {31'b0, ren}, {31'b0, expRenMask[c]});
            checkOutput($sformatf("%s valid c%0d", tag, c), {31'b0, rtr.router_valid_in},
                        {31'b0, (expLbl[c] >= 0)});
            if (expLbl[c] >= 0) begin
                checkOutput($sformatf("%s label c%0d", tag, c),
                            {30'b0, rtr.router_data_in.flit_label}, expLbl[c]);
                checkOutput($sformatf("%s vc c%0d", tag, c),
                            {31'b0, rtr.router_data_in.vc_id}, {31'b0, expVc[c]});
                checkOutput($sformatf("%s data c%0d", tag, c), rtr.router_data_in.data, expDat[c]);
            end
            @(posedge clk);
            #1;
            if (sRen && txQ.size() > 0) begin
                rdata = txQ.pop_front();
            end
            rempty = (txQ.size() == 0);
        end
    endtask

    task automatic applyStimulus(input ejVec_t v);
        rtr.router_valid_out            = v.vld;
        rtr.router_data_out.flit_label  = v.lbl;
        rtr.router_data_out.vc_id       = v.vc;
        rtr.router_data_out.data        = v.data;
        wafull                          = v.wafull;
    endtask

    task automatic checkRow(input ejVec_t v, input int i);
        checkOutput($sformatf("ej%0d wen", i), {31'b0, wen}, {31'b0, v.eWen});
        if (v.eWen) begin
            checkOutput($sformatf("ej%0d wdata", i), wdata, v.eWdata);
        end
        checkOutput($sformatf("ej%0d grant vld", i), {31'b0, gVld}, {31'b0, v.eVld});
        if (v.eVld) begin
            checkOutput($sformatf("ej%0d grant x", i), {28'b0, gX}, {28'b0, v.eX});
            checkOutput($sformatf("ej%0d grant y", i), {28'b0, gY}, {28'b0, v.eY});
            checkOutput($sformatf("ej%0d grant dla", i), {30'b0, gDla}, {30'b0, v.eDla});
        end
        checkOutput($sformatf("ej%0d err_seq", i), {31'b0, errSeq}, {31'b0, v.eErr});
        checkOutput($sformatf("ej%0d rx_cnt", i), {16'b0, rxCnt}, {16'b0, v.eRx});
        checkOutput($sformatf("ej%0d alloc", i), {30'b0, rtr.router_is_allocatable_in}, {30'b0, v.eAlloc});
        checkOutput($sformatf("ej%0d on_off_in", i), {30'b0, rtr.router_is_on_off_in}, {30'b0, v.eOnOff});
    endtask

    task automatic checkResetState(input string tag);
        checkOutput({tag, " valid_in"}, {31'b0, rtr.router_valid_in}, 32'd0);
        checkOutput({tag, " label"}, {30'b0, rtr.router_data_in.flit_label}, 32'd3);
        checkOutput({tag, " wen"}, {31'b0, wen}, 32'd0);
        checkOutput({tag, " grant vld"}, {31'b0, gVld}, 32'd0);
        checkOutput({tag, " err_seq"}, {31'b0, errSeq}, 32'd0);
        checkOutput({tag, " tx_cnt"}, {16'b0, txCnt}, 32'd0);
        checkOutput({tag, " rx_cnt"}, {16'b0, rxCnt}, 32'd0);
        checkOutput({tag, " alloc"}, {30'b0, rtr.router_is_allocatable_in}, 32'd3);
    endtask

    logic [31:0] h0, h1, h2, hdr;

    initial begin
        // Ejection table: {vld, label, vc, data, wafull, wen, wdata, gvld, x, y, dla, err, rx, alloc, on_off_in}
        vecs[0] = '{1'b1, HEAD,     1'b1, 32'hD000_0000, 1'b0, 1'b0, 32'h0,          1'b0, 4'd0, 4'd0, 2'd0, 1'b0, 16'd0, 2'b01, 2'b11};
        vecs[1] = '{1'b1, BODY,     1'b1, 32'hD000_0001, 1'b0, 1'b1, 32'hD000_0001, 1'b0, 4'd0, 4'd0, 2'd0, 1'b0, 16'd0, 2'b01, 2'b11};
        vecs[2] = '{1'b1, BODY,     1'b1, 32'hD000_0002, 1'b0, 1'b1, 32'hD000_0002, 1'b0, 4'd0, 4'd0, 2'd0, 1'b0, 16'd0, 2'b01, 2'b11};
        vecs[3] = '{1'b1, TAIL,     1'b1, 32'hD000_0003, 1'b0, 1'b1, 32'hD000_0003, 1'b0, 4'd0, 4'd0, 2'd0, 1'b0, 16'd1, 2'b11, 2'b11};
        vecs[4] = '{1'b0, BODY,     1'b0, 32'h0,         1'b1, 1'b0, 32'h0,          1'b0, 4'd0, 4'd0, 2'd0, 1'b0, 16'd1, 2'b11, 2'b00};
        vecs[5] = '{1'b1, HEADTAIL, 1'b0, 32'h1200_014E, 1'b0, 1'b0, 32'h0,          1'b1, 4'd5, 4'd3, 2'd2, 1'b0, 16'd2, 2'b11, 2'b11};
        vecs[6] = '{1'b0, BODY,     1'b0, 32'h0,         1'b0, 1'b0, 32'h0,          1'b0, 4'd0, 4'd0, 2'd0, 1'b0, 16'd2, 2'b11, 2'b11};
        vecs[7] = '{1'b1, BODY,     1'b0, 32'hD000_0004, 1'b0, 1'b1, 32'hD000_0004, 1'b0, 4'd0, 4'd0, 2'd0, 1'b1, 16'd2, 2'b11, 2'b11};
        vecs[8] = '{1'b0, BODY,     1'b0, 32'h0,         1'b0, 1'b0, 32'h0,          1'b0, 4'd0, 4'd0, 2'd0, 1'b1, 16'd2, 2'b11, 2'b11};
        vecs[9] = '{1'b0, BODY,     1'b0, 32'h0,         1'b0, 1'b0, 32'h0,          1'b0, 4'd0, 4'd0, 2'd0, 1'b1, 16'd2, 2'b11, 2'b11};

        rstN                     = 1'b0;
        wafull                   = 1'b0;
        rempty                   = 1'b1;
        rdata                    = 32'h0;
        rtr.router_valid_out     = 1'b0;
        rtr.router_data_out      = '0;
        rtr.router_is_on_off_out = 2'b11;

        repeat (3) @(posedge clk);
        #1;
        checkResetState("reset");
        checkOutput("reset ren", {31'b0, ren}, 32'd0);
        rstN = 1'b1;

        // Single-flit packets alternate VCs starting from VC0
        $display("[TB] single-flit packets");
        h0 = mkHdr(4'd1, 4'd1, 3'd0, 8'd0, 13'h0011);
        h1 = mkHdr(4'd2, 4'd2, 3'd1, 8'd0, 13'h0022);
        h2 = mkHdr(4'd3, 4'd3, 3'd2, 8'd0, 13'h0033);
        pushWord(h0); pushWord(h1); pushWord(h2);
        clearSched();
        expRenMask = 16'b0000_0000_0001_0101;
        expLbl[2] = 3; expVc[2] = 1'b0; expDat[2] = h0;
        expLbl[4] = 3; expVc[4] = 1'b1; expDat[4] = h1;
        expLbl[6] = 3; expVc[6] = 1'b0; expDat[6] = h2;
        runInj(8, "ht");
        checkOutput("ht tx_cnt", {16'b0, txCnt}, 32'd3);

        // len=3 at full rate on VC1
        $display("[TB] len=3 packet");
        hdr = mkHdr(4'd6, 4'd7, 3'd1, 8'd3, 13'h00AB);
        pushWord(hdr); pushWord(32'hA000_0001); pushWord(32'hA000_0002); pushWord(32'hA000_0003);
        clearSched();
        expRenMask = 16'b0000_0000_0001_1101;
        expLbl[2] = 0; expVc[2] = 1'b1; expDat[2] = stripLen(hdr);
        expLbl[4] = 1; expVc[4] = 1'b1; expDat[4] = 32'hA000_0001;
        expLbl[5] = 1; expVc[5] = 1'b1; expDat[5] = 32'hA000_0002;
        expLbl[6] = 2; expVc[6] = 1'b1; expDat[6] = 32'hA000_0003;
        runInj(9, "len3");
        checkOutput("len3 tx_cnt", {16'b0, txCnt}, 32'd4);

        // len=4 on VC0 with VC0 switched off for three cycles mid-body
        $display("[TB] len=4 packet with on/off pause");
        hdr = mkHdr(4'd9, 4'd2, 3'd3, 8'd4, 13'h1234);
        pushWord(hdr);
        pushWord(32'hB000_0001); pushWord(32'hB000_0002); pushWord(32'hB000_0003); pushWord(32'hB000_0004);
        clearSched();
        onOffSched[4] = 2'b10; onOffSched[5] = 2'b10; onOffSched[6] = 2'b10;
        expRenMask = 16'b0000_0001_1000_1101;
        expLbl[2]  = 0; expVc[2]  = 1'b0; expDat[2]  = stripLen(hdr);
        expLbl[4]  = 1; expVc[4]  = 1'b0; expDat[4]  = 32'hB000_0001;
        expLbl[5]  = 1; expVc[5]  = 1'b0; expDat[5]  = 32'hB000_0002;
        expLbl[9]  = 1; expVc[9]  = 1'b0; expDat[9]  = 32'hB000_0003;
        expLbl[10] = 2; expVc[10] = 1'b0; expDat[10] = 32'hB000_0004;
        runInj(13, "len4");
        checkOutput("len4 tx_cnt", {16'b0, txCnt}, 32'd5);

        // Ejection table, ending with a BODY on an idle VC
        $display("[TB] ejection table");
        for (int i = 0; i < 10; i++) begin
            applyStimulus(vecs[i]);
            @(posedge clk);
            #1;
            checkRow(vecs[i], i);
        end
        rtr.router_valid_out = 1'b0;
        wafull               = 1'b0;

        // Reset in the middle of a packet: no tail afterwards, FSM back in IDLE
        $display("[TB] reset mid-packet");
        hdr = mkHdr(4'd4, 4'd4, 3'd0, 8'd4, 13'h0F0F);
        pushWord(hdr);
        pushWord(32'hC000_0001); pushWord(32'hC000_0002); pushWord(32'hC000_0003); pushWord(32'hC000_0004);
        clearSched();
        expRenMask = 16'b0000_0000_0000_1101;
        expLbl[2] = 0; expVc[2] = 1'b1; expDat[2] = stripLen(hdr);
        runInj(4, "pre");
        txQ.delete();
        rempty = 1'b1;
        rstN   = 1'b0;
        @(posedge clk);
        #1;
        rstN = 1'b1;
        checkResetState("midrst");
        clearSched();
        runInj(5, "postrst");
        h0 = mkHdr(4'd8, 4'd1, 3'd1, 8'd0, 13'h0055);
        pushWord(h0);
        clearSched();
        expRenMask = 16'b0000_0000_0000_0001;
        expLbl[2] = 3; expVc[2] = 1'b0; expDat[2] = h0;
        runInj(4, "afterrst");
        checkOutput("afterrst tx_cnt", {16'b0, txCnt}, 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

endmodule

// File: doc/noc_vc_bridge.md
# noc_vc_bridge

Single-clock, VC-parametrised network-interface bridge between one router local port and the local TX/RX buffers. It packetises header-prefixed words from the TX buffer into HEAD/BODY/TAIL/HEADTAIL flits, choosing the VC round-robin under per-VC on/off flow control. It also depacketises ejected flits into the RX buffer and a grant pulse. Per-VC sequence checking and packet counters are included.

## Interface

Parameters:
- NVC, default VC_NUM: number of virtual channels (≥1).
- LEN_W, default 8: width of the header payload-length field.
- EJECT_HEAD, default 0: when 1, HEAD flit data is also written to the RX buffer.
- CNT_W, default 16: width of the packet counters.

Ports:
- clk_router  in  1  clock.
- rst_router_n  in  1  reset. One clock; reset is synchronous and active-low.
- router_data_in  out  flit_t  flit injected into the router.
- router_valid_in  out  1  injected flit valid.
- router_is_on_off_in  out  NVC  per-VC on/off to the router, equal to {NVC{!router_wrbuf_wafull}}.
- router_is_allocatable_in  out  NVC  bit v = !rx_inpkt[v].
- router_data_out  in  flit_t  ejected flit.
- router_valid_out  in  1  ejected flit valid.
- router_is_on_off_out  in  NVC  downstream per-VC on/off.
- router_wrbuf_wafull  in  1  RX buffer almost-full.
- router_wrbuf_wen  out  1  RX buffer write enable.
- router_wrbuf_wdata  out  FLIT_DATA_SIZE  RX buffer write data.
- router_rdbuf_rempty  in  1  TX buffer empty.
- router_rdbuf_ren  out  1  TX buffer read. Combinational. Read data is valid the following cycle.
- router_rdbuf_rdata  in  FLIT_DATA_SIZE  TX buffer read data.
- dla2noc_granted_x / _y / _dla / _vld  out  DEST_ADDR_SIZE_X / DEST_ADDR_SIZE_Y / 2 / 1  grant fields and strobe.
- err_seq  out  1  sticky sequence-error flag.
- tx_pkt_cnt, rx_pkt_cnt  out  CNT_W  wrapping packet counters.

## Operation

Reset: all registered outputs are 0. Exceptions: router_data_in.flit_label resets to HEADTAIL; state resets to IDLE; the RR pointer resets to NVC-1; rx_inpkt resets to 0.

Header word fields (FDS = FLIT_DATA_SIZE):
- x = [FDS-1:FDS-4]
- y = [FDS-5:FDS-8]
- l = [FDS-9:FDS-11]
- len = [FDS-12:FDS-11-LEN_W], the number of payload words that follow.
- head_pl = remaining low bits.

Injection FSM:
- IDLE:
  - Condition: !rempty && |router_is_on_off_out.
  - On the condition, ren=1 and the VC is picked as the first v with on_off[v]=1, scanning from ptr+1 upward modulo NVC.
  - ptr and cur_vc are set to that v.
  - Next state is HDR.
- HDR (header word present on rdata):
  - Load a flit with vc_id=cur_vc and the x/y/l/head_pl fields.
  - Label is HEADTAIL if len==0, else HEAD.
  - rd_left=len, sent=0.
  - Next state is IDLE if len==0, else BODY.
- BODY:
  - ren = !rempty && on_off[cur_vc] && rd_left!=0.
  - Each issued read decrements rd_left; reads may be issued back-to-back.
  - When a BODY-issued read's data is present, load a flit with data=rdata and vc_id=cur_vc, then increment sent.
  - Label is TAIL if sent==len-1, else BODY. On TAIL, next state is IDLE.
  - Reads already issued are always emitted, even if on_off drops.
- tx_pkt_cnt increments on each HEAD or HEADTAIL load.

Ejection (when router_valid_out=1; flit VC v = vc_id):
- HEADTAIL:
  - Pulse dla2noc_granted_vld with dla = head_pl[1:0], y = head_pl[2+:Y], x = head_pl[2+Y+:X].
  - Write to the RX buffer only if EJECT_HEAD=1.
  - Increment rx_pkt_cnt.
  - If rx_inpkt[v] is set, set err_seq.
- HEAD:
  - Set rx_inpkt[v].
  - Write to the RX buffer only if EJECT_HEAD=1.
  - If rx_inpkt[v] was already set, set err_seq.
- BODY: write the RX buffer. If !rx_inpkt[v], set err_seq.
- TAIL:
  - Write the RX buffer and clear rx_inpkt[v].
  - Increment rx_pkt_cnt.
  - If !rx_inpkt[v], set err_seq.
- err_seq is cleared only by reset. An erroneous flit is still written.

## Timing

- Injection latency:
  - ren in cycle t yields the corresponding router_valid_in in cycle t+2.
  - The head flit is valid 2 cycles after the IDLE read.
  - A full-rate packet of len words occupies len+2 cycles from first read to tail.
- After a TAIL or HEADTAIL load, the FSM is in IDLE on the next cycle. The next header read is issued no earlier than that cycle.
- Ejection:
  - router_wrbuf_wen/wdata and dla2noc_granted_* are registered, so a flit in cycle t appears in t+1.
  - Strobes are one cycle wide and zero otherwise.
- router_is_on_off_in follows wafull combinationally.
- Counters wrap modulo 2^CNT_W.
- Injection and ejection are independent and may be active in the same cycle.
- Reset mid-packet: the next cycle is IDLE; no partial tail is emitted.

## Test plan

- Single-flit packets (header len=0) on 2 VCs with on_off=2'b11: expect HEADTAIL flits with vc_id alternating 0,1,0; tx_pkt_cnt=3.
- len=3, empty never asserted: expect ren in cycles 0,2,3,4, then HEAD, BODY, BODY, TAIL in cycles 2,4,5,6.
- len=4 with on_off[cur_vc] dropped for 3 cycles mid-body: ren pauses, sent flits stay in order, and exactly 1 TAIL is emitted.
- Eject HEAD, BODY×2, TAIL on VC1 with EJECT_HEAD=0: 3 writes, allocatable[1]=0 between HEAD and TAIL, rx_pkt_cnt=1, err_seq=0.
- Eject HEADTAIL with head_pl low bits = {x=5, y=3, dla=2}: one vld pulse with x=5, y=3, dla=2, and no wen.
- Eject a BODY on an idle VC: err_seq=1 and stays 1. Reset clears it and returns the FSM to IDLE mid-packet.
